// File: rtl/lzc_pkg.sv
// Shared helpers for the leading-zero coder blocks: clog2 and count-width derivation.
package lzc_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Count width must hold 0..DATA_W inclusive, hence the extra bit.
  function automatic int unsigned cnt_w(input int unsigned data_w);
    return clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational halving priority tree: index of the highest set bit and all-zero flag.
module lzc_tree
  import lzc_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned POS_W  = clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] word,
  output logic [POS_W-1:0]  msb_pos,
  output logic              zero
);

  logic [DATA_W-1:0] w_win;
  logic [DATA_W-1:0] w_hi;
  logic              w_hit;
  logic [POS_W-1:0]  w_pos;

  // Each level keeps the upper half of the window if it is nonzero, else the lower half.
  always_comb begin
    w_win = word;
    w_hi  = '0;
    w_hit = 1'b0;
    w_pos = '0;
    for (int l = int'(POS_W) - 1; l >= 0; l--) begin
      w_hi  = w_win >> (1 << l);
      w_hit = |w_hi;
      w_pos = {w_pos[POS_W-2:0], w_hit};
      w_win = w_hit ? w_hi : (w_win & ~({DATA_W{1'b1}} << (1 << l)));
    end
  end

  assign msb_pos = w_pos;
  assign zero    = ~|word;

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero count and normalise pipeline with valid/ready handshake.
// Optional zero-word statistics counter enabled by defining LZC_NORM_STATS_EN.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned CNT_W  = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  times,
  output logic [CNT_W-2:0]  msb_pos,
  output logic              zero,
  output logic [DATA_W-1:0] data_norm
`ifdef LZC_NORM_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       zero_cnt
`endif
);

  localparam int unsigned POS_W = CNT_W - 1;

  logic              w_s2_adv;
  logic              w_accept;
  logic [POS_W-1:0]  w_pos;
  logic              w_zero;
  logic [CNT_W-1:0]  w_times;
  logic [DATA_W-1:0] w_shift;
  logic [POS_W-1:0]  w_amt;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_word;
  logic [CNT_W-1:0]  r_s1_times;
  logic [POS_W-1:0]  r_s1_pos;
  logic              r_s1_zero;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_norm;
  logic [CNT_W-1:0]  r_s2_times;
  logic [POS_W-1:0]  r_s2_pos;
  logic              r_s2_zero;

  lzc_tree #(.DATA_W(DATA_W)) u_tree (
    .word    (data_in),
    .msb_pos (w_pos),
    .zero    (w_zero)
  );

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;
  assign w_times  = w_zero ? CNT_W'(DATA_W) : (CNT_W'(DATA_W - 1) - CNT_W'(w_pos));

  // Log-depth barrel shifter; a zero word stays zero so the count's top bit is never needed.
  always_comb begin
    w_shift = r_s1_word;
    w_amt   = r_s1_times[POS_W-1:0];
    for (int k = 0; k < int'(POS_W); k++) begin
      if (w_amt[0]) w_shift = w_shift << (1 << k);
      w_amt = w_amt >> 1;
    end
  end

  // Stage 1: register the word and its tree results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_times <= '0;
      r_s1_pos   <= '0;
      r_s1_zero  <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_word  <= data_in;
        r_s1_times <= w_times;
        r_s1_pos   <= w_pos;
        r_s1_zero  <= w_zero;
      end
    end
  end

  // Stage 2: register the normalised word; holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_norm  <= '0;
      r_s2_times <= '0;
      r_s2_pos   <= '0;
      r_s2_zero  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_norm  <= w_shift;
        r_s2_times <= r_s1_times;
        r_s2_pos   <= r_s1_pos;
        r_s2_zero  <= r_s1_zero;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign times     = r_s2_times;
  assign msb_pos   = r_s2_pos;
  assign zero      = r_s2_zero;
  assign data_norm = r_s2_norm;

`ifdef LZC_NORM_STATS_EN
  logic [15:0] r_zero_cnt;

  // Saturating count of emitted all-zero words; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_cnt <= '0;
    end else if (stats_clr) begin
      r_zero_cnt <= '0;
    end else if (r_s2_valid && out_ready && r_s2_zero && (r_zero_cnt != 16'hFFFF)) begin
      r_zero_cnt <= r_zero_cnt + 16'd1;
    end
  end

  assign zero_cnt = r_zero_cnt;
`endif

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed and scoreboard-checked bench for lzc_norm_pipe at DATA_W=16.
module tb_lzc_norm_pipe;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  times;
  logic [CNT_W-2:0]  msb_pos;
  logic              zero;
  logic [DATA_W-1:0] data_norm;
`ifdef LZC_NORM_STATS_EN
  logic              stats_clr;
  logic [15:0]       zero_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  lzc_norm_pipe #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .times     (times),
    .msb_pos   (msb_pos),
    .zero      (zero),
    .data_norm (data_norm)
`ifdef LZC_NORM_STATS_EN
    ,
    .stats_clr (stats_clr),
    .zero_cnt  (zero_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int t, input int p, input logic z,
                         input logic [15:0] n);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".times"}, 64'(times), 64'(t));
    chk({tag, ".msb_pos"}, 64'(msb_pos), 64'(p));
    chk({tag, ".zero"}, 64'(zero), 64'(z));
    chk({tag, ".norm"}, 64'(data_norm), 64'(n));
  endtask

  // Single word through an otherwise idle pipe: visible exactly two edges after accept.
  task automatic run_vec(input string tag, input logic [15:0] w, input int t, input int p,
                         input logic z, input logic [15:0] n);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = w;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    data_in  = '0;
    chk({tag, ".lat1"}, 64'(out_valid), 64'd0);
    step();
    chk_out(tag, t, p, z, n);
  endtask

  // Reference: linear scan from the top bit.
  function automatic void model(input logic [15:0] w, output int t, output int p,
                                output logic z, output logic [15:0] n);
    logic found;
    found = 1'b0;
    t = 16;
    for (int i = 15; i >= 0; i--) begin
      if (!found && w[i]) begin
        found = 1'b1;
        t = 15 - i;
      end
    end
    z = !found;
    p = found ? 15 - t : 0;
    n = found ? (w << t) : 16'h0000;
  endfunction

  initial begin
    int t, p;
    logic z;
    logic [15:0] n, w;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
`ifdef LZC_NORM_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.times", 64'(times), 64'd0);
    chk("rst.msb_pos", 64'(msb_pos), 64'd0);
    chk("rst.zero", 64'(zero), 64'd0);
    chk("rst.norm", 64'(data_norm), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_vec("v0001", 16'h0001, 15, 0, 1'b0, 16'h8000);
    run_vec("v8000", 16'h8000, 0, 15, 1'b0, 16'h8000);
    run_vec("v00F3", 16'h00F3, 8, 7, 1'b0, 16'hF300);
    run_vec("v1234", 16'h1234, 3, 12, 1'b0, 16'h91A0);
    run_vec("v7FFF", 16'h7FFF, 1, 14, 1'b0, 16'hFFFE);
    run_vec("v0000", 16'h0000, 16, 0, 1'b1, 16'h0000);
`ifdef LZC_NORM_STATS_EN
    chk("stats.before", 64'(zero_cnt), 64'd0);
    step();
    chk("stats.after", 64'(zero_cnt), 64'd1);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats.clr", 64'(zero_cnt), 64'd0);
`endif
    step();
    chk("idle.out_valid", 64'(out_valid), 64'd0);

    // Backpressure: fill both stages, stall, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 16'h0100;
    step();
    data_in = 16'h0010;
    #1;
    chk("bp.ready_s2_empty", 64'(in_ready), 64'd1);
    step();
    data_in = 16'h0001;
    #1;
    chk("bp.ready_low", 64'(in_ready), 64'd0);
    chk_out("bp.first", 7, 8, 1'b0, 16'h8000);
    step();
    chk("bp.hold1.ready", 64'(in_ready), 64'd0);
    chk_out("bp.hold1", 7, 8, 1'b0, 16'h8000);
    step();
    chk_out("bp.hold2", 7, 8, 1'b0, 16'h8000);
    out_ready = 1'b1;
    #1;
    chk("bp.ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp.second", 11, 4, 1'b0, 16'h8000);
    step();
    chk_out("bp.third", 15, 0, 1'b0, 16'h8000);
    step();
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Reset with two words in flight.
    in_valid = 1'b1;
    data_in  = 16'h0F00;
    step();
    data_in = 16'h00F0;
    step();
    in_valid = 1'b0;
    chk("rmid.pre", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid.out_valid", 64'(out_valid), 64'd0);
    chk("rmid.in_ready", 64'(in_ready), 64'd1);
    chk("rmid.times", 64'(times), 64'd0);
    chk("rmid.norm", 64'(data_norm), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rmid.no_stale", 64'(out_valid), 64'd0);
    end
    run_vec("post_rst", 16'h0001, 15, 0, 1'b0, 16'h8000);
    step();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      data_in   = 16'($urandom) >> $urandom_range(0, 16);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand.spurious", 64'd1, 64'd0);
        end else begin
          w = q.pop_front();
          model(w, t, p, z, n);
          chk_out("rand", t, p, z, n);
        end
      end
      if (in_valid && in_ready) q.push_back(data_in);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("drain.spurious", 64'd1, 64'd0);
        end else begin
          w = q.pop_front();
          model(w, t, p, z, n);
          chk_out("drain", t, p, z, n);
        end
      end
      @(posedge clk);
      #1;
    end
    chk("drain.empty", 64'(q.size()), 64'd0);
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
